// File: rtl/fifo_read_streamer_if.sv
`default_nettype none
// ============================================================================
// fifo_read_streamer_if : FIFO read port + valid/ready output stream bundle
// Revision: 1.0
// ============================================================================
interface fifo_read_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_rd_en,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_rd_en,
    input  out_data,
    input  out_valid
  );
endinterface
`default_nettype wire

// File: rtl/fifo_read_streamer.sv
`default_nettype none
// ============================================================================
// fifo_read_streamer : pops an async FIFO read port into a 2-entry skid stream
// Revision: 1.0
// ============================================================================
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  enable,
  fifo_read_streamer_if.master  bus,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);

  localparam logic [1:0] c_occ_empty = 2'd0;
  localparam logic [1:0] c_occ_one   = 2'd1;
  localparam logic [1:0] c_occ_two   = 2'd2;

  logic                  r_inflight;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_entry0;
  logic [DATA_WIDTH-1:0] r_entry1;
  logic [CNT_WIDTH-1:0]  r_word_count;

  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_committed;
  logic                  w_rd_en;

  assign w_push = r_inflight;
  assign w_pop  = (r_occ != c_occ_empty) & bus.out_ready;

  // Counting the same-cycle pop lets a read issue behind a departing head,
  // which sustains one word per cycle while still bounding occ+inflight to 2.
  assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en     = enable & ~bus.fifo_empty & ~rst & (w_committed < 3'd2);

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      r_inflight   <= 1'b0;
      r_occ        <= c_occ_empty;
      r_entry0     <= '0;
      r_entry1     <= '0;
      r_word_count <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) begin
        r_word_count <= r_word_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      case (r_occ)
        c_occ_empty: begin
          if (w_push) begin
            r_entry0 <= bus.fifo_data;
            r_occ    <= c_occ_one;
          end
        end
        c_occ_one: begin
          if (w_push && w_pop) begin
            r_entry0 <= bus.fifo_data;
          end else if (w_push) begin
            r_entry1 <= bus.fifo_data;
            r_occ    <= c_occ_two;
          end else if (w_pop) begin
            r_occ <= c_occ_empty;
          end
        end
        c_occ_two: begin
          if (w_pop) begin
            r_entry0 <= r_entry1;
            if (w_push) begin
              r_entry1 <= bus.fifo_data;
            end else begin
              r_occ <= c_occ_one;
            end
          end
        end
        default: r_occ <= c_occ_empty;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A capture arriving while both entries are full would be lost.
  always @(posedge rd_clk) begin
    if (!rst) begin
      assert (!(r_occ == c_occ_two && w_push));
    end
  end
`endif

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = (r_occ != c_occ_empty);
  assign bus.out_data   = r_entry0;
  assign word_count     = r_word_count;
  assign busy           = r_inflight | (r_occ != c_occ_empty);

endmodule
`default_nettype wire
